bcd_to_bin_decoder: RTL and testbench

- Serial reverse double-dabble converter: packed BCD (P_DIGITS nibbles) in, unsigned binary out.
- Counterpart of the team's binary-to-BCD encoder path, so display or keypad BCD values can be turned back into binary counts (for example, divider limits).
- Multi-cycle with a start/busy/done handshake: one shift per clock, no combinational divide or multiply.

---
 rtl/bcd_dec_pkg.sv | 36 +++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bcd_to_bin_decoder.sv | 162 ++++++++++++++++
 tb/tb_bcd_to_bin_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_dec_pkg.sv
// ============================================================================
// Module : bcd_dec_pkg
// Brief  : Shared types, constants and elaboration helpers for the serial
//          BCD-to-binary decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_dec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int C_DIGIT_W = 4;

    function automatic int calc_cnt_w(input int digits);
        return $clog2(C_DIGIT_W * digits + 1);
    endfunction

    // True when bin_w bits can hold the largest P_DIGITS-digit decimal value.
    function automatic bit bin_w_ok(input int digits, input int bin_w);
        longint max_val;
        max_val = 1;
        for (int i = 0; i < digits; i++) begin
            max_val = max_val * 10;
        end
        max_val = max_val - 1;
        return (bin_w >= 63) || ((max_val >> bin_w) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// Module : bcd_digit_adj
// Brief  : Reverse double-dabble digit correction: subtract 3 when digit >= 8.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = i_digit[3] ? (i_digit - 4'd3) : i_digit;

endmodule

`default_nettype wire

// File: rtl/bcd_to_bin_decoder.sv
// ============================================================================
// Module : bcd_to_bin_decoder
// Brief  : Serial reverse double-dabble converter, packed BCD in, binary out,
//          one shift per clock with start/busy/done handshake.
//          Optional macro BCD_DEC_CHECK_EN adds invalid-digit detection (o_err).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_to_bin_decoder
    import bcd_dec_pkg::*;
#(
    parameter int P_DIGITS = 4,
    parameter int P_BIN_W  = 14
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic [4*P_DIGITS-1:0]       i_bcd,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [P_BIN_W-1:0]          o_data
`ifdef BCD_DEC_CHECK_EN
    ,
    output logic                        o_err
`endif
);

    localparam int C_W     = C_DIGIT_W * P_DIGITS;
    localparam int C_CNT_W = calc_cnt_w(P_DIGITS);

    if (!bin_w_ok(P_DIGITS, P_BIN_W)) begin : g_bin_w_check
        $error("bcd_to_bin_decoder: P_BIN_W too narrow for P_DIGITS");
    end

    state_t                 r_state;
    state_t                 w_next_state;
    logic [C_W-1:0]         r_bcd;
    logic [C_W-1:0]         r_bin;
    logic [C_CNT_W-1:0]     r_cnt;
    logic                   r_done;
    logic [P_BIN_W-1:0]     r_data;

    logic                   w_busy;
    logic                   w_load;
    logic                   w_step;
    logic                   w_finish;
    logic                   w_last;
    logic                   w_force_zero;
    logic [2*C_W-1:0]       w_cat;
    logic [C_W-1:0]         w_bcd_pre;
    logic [C_W-1:0]         w_bcd_adj;
    logic [C_W-1:0]         w_bin_next;
    logic [P_BIN_W-1:0]     w_bin_out;

    // Shift {bcd,bin} right; bcd LSB drops into the bin MSB.
    assign w_cat      = {r_bcd, r_bin} >> 1;
    assign w_bcd_pre  = w_cat[2*C_W-1:C_W];
    assign w_bin_next = w_cat[C_W-1:0];
    assign w_last     = (r_cnt == C_CNT_W'(C_W - 1));

    for (genvar g = 0; g < P_DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .i_digit (w_bcd_pre[g*C_DIGIT_W +: C_DIGIT_W]),
            .o_digit (w_bcd_adj[g*C_DIGIT_W +: C_DIGIT_W])
        );
    end

    if (P_BIN_W <= C_W) begin : g_out_slice
        assign w_bin_out = r_bin[P_BIN_W-1:0];
    end else begin : g_out_ext
        assign w_bin_out = {{(P_BIN_W - C_W){1'b0}}, r_bin};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next_state = SHIFT;
            SHIFT:   if (w_last)  w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_busy   = 1'b0;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            IDLE:    w_load = i_start;
            SHIFT:   begin w_busy = 1'b1; w_step = 1'b1; end
            DONE:    begin w_busy = 1'b1; w_finish = 1'b1; end
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bcd  <= '0;
            r_bin  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_data <= '0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_bcd <= i_bcd;
                r_bin <= '0;
                r_cnt <= '0;
            end else if (w_step) begin
                r_bcd <= w_bcd_adj;
                r_bin <= w_bin_next;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_finish) begin
                r_data <= w_force_zero ? '0 : w_bin_out;
            end
        end
    end

`ifdef BCD_DEC_CHECK_EN
    logic [P_DIGITS-1:0] w_nib_bad;
    logic                r_bad;
    logic                r_err;

    for (genvar g = 0; g < P_DIGITS; g++) begin : g_nib_check
        assign w_nib_bad[g] = (i_bcd[g*C_DIGIT_W +: C_DIGIT_W] > 4'd9);
    end

    // Error is captured with the operand but only published with the result.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bad <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_load)   r_bad <= |w_nib_bad;
            if (w_finish) r_err <= r_bad;
        end
    end

    assign w_force_zero = r_bad;
    assign o_err        = r_err;
`else
    assign w_force_zero = 1'b0;
`endif

    assign o_busy = w_busy;
    assign o_done = r_done;
    assign o_data = r_data;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin_decoder.sv
// ============================================================================
// Module : tb_bcd_to_bin_decoder
// Brief  : Scoreboard bench for bcd_to_bin_decoder (directed BCD vectors).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_bin_decoder;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int LAT    = 4 * DIGITS + 2;

    typedef struct {
        logic [BIN_W-1:0] data;
        logic             err;
        int               due;
    } exp_t;

    logic                  clk;
    logic                  i_reset;
    logic                  i_start;
    logic [4*DIGITS-1:0]   i_bcd;
    logic                  o_busy;
    logic                  o_done;
    logic [BIN_W-1:0]      o_data;
    logic                  o_err;

    exp_t sb[$];
    int   n_checks;
    int   n_errors;
    int   ncyc;

    bcd_to_bin_decoder #(.P_DIGITS(DIGITS), .P_BIN_W(BIN_W)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_bcd   (i_bcd),
        .o_busy  (o_busy),
        .o_done  (o_done),
`ifdef BCD_DEC_CHECK_EN
        .o_data  (o_data),
        .o_err   (o_err)
`else
        .o_data  (o_data)
`endif
    );

`ifndef BCD_DEC_CHECK_EN
    assign o_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation on every o_done and checks value and timing.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        ncyc = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (o_done === 1'b1) begin
                if (prev_done === 1'b1) chk("done_pulse_width", 32'd2, 32'd1);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("data", 32'(o_data), 32'(e.data));
                    chk("latency_cycle", ncyc, e.due);
`ifdef BCD_DEC_CHECK_EN
                    chk("err", 32'(o_err), 32'(e.err));
`endif
                end
            end
            prev_done = o_done;
        end
    end

    // Present a start for one edge; returns #1 after the accepting edge.
    task automatic issue(input logic [15:0] bcd);
        @(posedge clk); #1;
        i_start = 1'b1;
        i_bcd   = bcd;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("busy_after_start", 32'(o_busy), 32'd1);
    endtask

    task automatic do_start(input logic [15:0] bcd, input int exp_val, input logic exp_err);
        exp_t e;
        issue(bcd);
        e.data = BIN_W'(exp_val);
        e.err  = exp_err;
        e.due  = ncyc + LAT;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk);
        chk("drain_pending", sb.size(), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        chk("busy_idle", 32'(o_busy), 32'd0);
    endtask

    initial begin
        exp_t e;
        n_checks = 0;
        n_errors = 0;
        i_reset  = 1'b1;
        i_start  = 1'b0;
        i_bcd    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_err",  32'(o_err),  32'd0);
        i_reset = 1'b0;

        do_start(16'h1234, 1234, 1'b0); drain();
        do_start(16'h9999, 9999, 1'b0); drain();
        do_start(16'h0000, 0,    1'b0); drain();
        do_start(16'h0001, 1,    1'b0); drain();

        // Start held high while busy must not queue a second conversion.
        do_start(16'h0042, 42, 1'b0);
        i_start = 1'b1;
        i_bcd   = 16'h7777;
        for (int k = 0; k < 40 && o_busy === 1'b1; k++) begin
            @(posedge clk); #1;
        end
        i_start = 1'b0;
        chk("busy_dropped", 32'(o_busy), 32'd0);
        drain();
        do_start(16'h7777, 7777, 1'b0); drain();

        // Back-to-back: restart in the o_done cycle, latency check gives 18 spacing.
        do_start(16'h0123, 123, 1'b0);
        for (int k = 0; k < 40 && o_done !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        chk("b2b_done_seen", 32'(o_done), 32'd1);
        i_start = 1'b1;
        i_bcd   = 16'h0456;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("b2b_accepted", 32'(o_busy), 32'd1);
        e.data = BIN_W'(456);
        e.err  = 1'b0;
        e.due  = ncyc + LAT;
        sb.push_back(e);
        drain();

        // Reset mid-conversion aborts without a done.
        issue(16'h5555);
        repeat (7) @(posedge clk);
        #1;
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_data", 32'(o_data), 32'd0);
        repeat (25) @(posedge clk);
        do_start(16'h0305, 305, 1'b0); drain();

`ifdef BCD_DEC_CHECK_EN
        do_start(16'h12A4, 0,  1'b1); drain();
        do_start(16'h0010, 10, 1'b0); drain();
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
